// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with centre sampling, a valid/ready output and framing/overrun pulses.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop (8E1).
module uart_rx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    // The counter reads 0 one cycle after t0, so CLKS_PER_BIT/2 - 1 lands on each bit centre.
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bit_q, par_bit_d;
    logic          parity_err_q, parity_err_d;
`endif

    logic rx_s;
    logic sample;

    assign rx_s   = sync2_q;
    assign sample = (cnt_q == CNT_SAMPLE);

    // Handshake: a byte transfers in any cycle where rx_valid & rx_ready are both high;
    // rx_data stays stable while rx_valid is high and rx_ready is ignored while rx_valid is low.
    always_comb begin
        state_d     = state_q;
        sync1_d     = rx_pin;
        sync2_d     = sync1_q;
        cnt_d       = (state_q == S_IDLE || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = (rx_valid_q && rx_ready) ? 1'b0 : rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 4'd0;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 4'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == 4'd7) state_d = S_PARITY;
`else
                    if (bit_idx_q == 4'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample) begin
                    par_bit_d = rx_s;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = (^shift_q) ^ par_bit_q;
`endif
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= 4'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
